// File: rtl/parser_field_extract_pkg.sv
// Shared parser definitions: stream widths, tag bit positions and the rule format.
package parser_field_extract_pkg;

  localparam int HEAD_WIDTH       = 512;
  localparam int META_WIDTH       = 256;
  localparam int TAG_WIDTH        = 3;
  localparam int TAG_START        = 2;
  localparam int TAG_VALID        = 1;
  localparam int TAG_TAIL         = 0;
  localparam int HEAD_SHIFT_WIDTH = 6;
  localparam int META_SHIFT_WIDTH = 5;
  localparam int KEY_FILED_NUM    = 2;
  localparam int KEY_FIELD_WIDTH  = 32;

  localparam int RULE_NUM_DEFAULT    = 8;
  localparam int TYPE_OFFSET_DEFAULT = 12;
  localparam int OFF_WIDTH_DEFAULT   = $clog2(HEAD_WIDTH / 8);

  // Per-rule action; key_off[0] sits in the most significant position.
  typedef struct packed {
    logic [HEAD_SHIFT_WIDTH-1:0]                    head_shift;
    logic [META_SHIFT_WIDTH-1:0]                    meta_shift;
    logic [0:KEY_FILED_NUM-1][OFF_WIDTH_DEFAULT-1:0] key_off;
  } action_t;

  // Packed rule as written through the config port; valid is the MSB.
  typedef struct packed {
    logic        valid;
    logic [15:0] type_value;
    logic [15:0] type_mask;
    action_t     action;
  } rule_t;

endpackage

// File: rtl/parser_rule_match.sv
// Rule table with a single write port and registered type-match vector.
module parser_rule_match
  import parser_field_extract_pkg::*;
#(
  parameter int RULE_NUM = RULE_NUM_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 type_field,
  input  logic                        wr_en,
  input  logic [$clog2(RULE_NUM)-1:0] wr_addr,
  input  rule_t                       wr_data,
  output logic [RULE_NUM-1:0]         hit,
  output action_t                     lookup_action [RULE_NUM]
);

  localparam int ADDR_WIDTH = $clog2(RULE_NUM);

  rule_t                 rule_tbl [RULE_NUM];
  logic [RULE_NUM-1:0]   hit_comb;
  logic                  shadow_en;
  logic [ADDR_WIDTH-1:0] shadow_addr;
  action_t               shadow_action;

  // Rule storage; reset clears every entry, so all rules come up invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RULE_NUM; i++) rule_tbl[i] <= '0;
    end else if (wr_en) begin
      rule_tbl[wr_addr] <= wr_data;
    end
  end

  // Masked compare of the slice type against every rule.
  always_comb begin
    hit_comb = '0;
    for (int unsigned i = 0; i < RULE_NUM; i++) begin
      hit_comb[i] = rule_tbl[i].valid &
                    (((type_field ^ rule_tbl[i].type_value) & rule_tbl[i].type_mask) == 16'h0000);
    end
  end

  // Match vector register feeding the priority encoder one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit <= '0;
    else        hit <= hit_comb;
  end

  // Remember the pre-write action of the entry written in the lookup cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_en     <= 1'b0;
      shadow_addr   <= '0;
      shadow_action <= '0;
    end else begin
      shadow_en     <= wr_en;
      shadow_addr   <= wr_addr;
      shadow_action <= rule_tbl[wr_addr].action;
    end
  end

  // Actions as they stood when the registered hit vector was formed: a write
  // in the lookup cycle has already landed, so that one entry is restored
  // from the shadow copy to keep hit and action from the same table version.
  always_comb begin
    for (int unsigned i = 0; i < RULE_NUM; i++) begin
      lookup_action[i] = rule_tbl[i].action;
      if (shadow_en && (shadow_addr == ADDR_WIDTH'(i))) lookup_action[i] = shadow_action;
    end
  end

endmodule

// File: rtl/parser_field_extract.sv
// Type-based rule lookup and key-field extraction aligned to the 2-cycle head/meta delay.
module parser_field_extract
  import parser_field_extract_pkg::*;
#(
  parameter int RULE_NUM    = RULE_NUM_DEFAULT,
  parameter int TYPE_OFFSET = TYPE_OFFSET_DEFAULT,
  parameter int OFF_WIDTH   = OFF_WIDTH_DEFAULT
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]           i_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0]           i_meta,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]           o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]           o_meta,
  output logic [HEAD_SHIFT_WIDTH-1:0]               o_headShift,
  output logic [META_SHIFT_WIDTH-1:0]               o_metaShift,
  output logic [KEY_FILED_NUM*KEY_FIELD_WIDTH-1:0]  o_extField,
  input  logic                                      i_cfg_wren,
  input  logic [$clog2(RULE_NUM)-1:0]               i_cfg_addr,
  input  logic [$bits(rule_t)-1:0]                  i_cfg_wdata
);

  localparam int IDX_WIDTH = $clog2(RULE_NUM);
  localparam int PAD_WIDTH = HEAD_WIDTH + KEY_FIELD_WIDTH;

  logic [15:0]                             type_field;
  logic                                    lookup;
  logic [RULE_NUM-1:0]                     hit;
  action_t                                 lookup_action [RULE_NUM];
  logic [HEAD_WIDTH+TAG_WIDTH-1:0]         head_d1;
  logic [META_WIDTH+TAG_WIDTH-1:0]         meta_d1;
  logic                                    start_d1;
  logic                                    win_found;
  logic [IDX_WIDTH-1:0]                    win_idx;
  action_t                                 win_action;
  logic [OFF_WIDTH-1:0]                    off;
  logic [PAD_WIDTH-1:0]                    padded;
  logic [PAD_WIDTH-1:0]                    shifted;
  logic [KEY_FILED_NUM*KEY_FIELD_WIDTH-1:0] ext_next;

  // Byte 0 of the slice occupies the data MSBs; the type is big-endian.
  assign type_field = i_head[HEAD_WIDTH-1-8*TYPE_OFFSET -: 16];
  assign lookup     = i_head[HEAD_WIDTH+TAG_START] & i_head[HEAD_WIDTH+TAG_VALID];

  parser_rule_match #(
    .RULE_NUM (RULE_NUM)
  ) u_rule_match (
    .clk           (i_clk),
    .rst_n         (i_rst_n),
    .type_field    (type_field),
    .wr_en         (i_cfg_wren),
    .wr_addr       (i_cfg_addr),
    .wr_data       (rule_t'(i_cfg_wdata)),
    .hit           (hit),
    .lookup_action (lookup_action)
  );

  // Two-stage delay of head/meta plus the start marker for the lookup stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_d1  <= '0;
      meta_d1  <= '0;
      start_d1 <= 1'b0;
      o_head   <= '0;
      o_meta   <= '0;
    end else begin
      head_d1  <= i_head;
      meta_d1  <= i_meta;
      start_d1 <= lookup;
      o_head   <= head_d1;
      o_meta   <= meta_d1;
    end
  end

  // Lowest-index hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < RULE_NUM; i++) begin
      if (hit[i] && !win_found) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(i);
      end
    end
    win_action = lookup_action[win_idx];
  end

  // Key-field extraction from the registered slice; zero padding past the
  // slice end makes out-of-range bytes read as 0.
  always_comb begin
    ext_next = '0;
    off      = '0;
    padded   = {head_d1[HEAD_WIDTH-1:0], {KEY_FIELD_WIDTH{1'b0}}};
    shifted  = '0;
    for (int unsigned k = 0; k < KEY_FILED_NUM; k++) begin
      off     = OFF_WIDTH'(win_action.key_off[k]);
      shifted = padded << {off, 3'b000};
      ext_next[(KEY_FILED_NUM-1-k)*KEY_FIELD_WIDTH +: KEY_FIELD_WIDTH] =
        shifted[PAD_WIDTH-1 -: KEY_FIELD_WIDTH];
    end
  end

  // Control outputs update with the start slice on o_head and hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_headShift <= '0;
      o_metaShift <= '0;
      o_extField  <= '0;
    end else if (start_d1) begin
      if (win_found) begin
        o_headShift <= win_action.head_shift;
        o_metaShift <= win_action.meta_shift;
        o_extField  <= ext_next;
      end else begin
        o_headShift <= '0;
        o_metaShift <= '0;
        o_extField  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_parser_field_extract.sv
// Scoreboard bench for parser_field_extract with a byte-level reference model.
module tb_parser_field_extract;
  import parser_field_extract_pkg::*;

  localparam int NB = HEAD_WIDTH / 8;
  localparam int HW = HEAD_WIDTH + TAG_WIDTH;
  localparam int MW = META_WIDTH + TAG_WIDTH;
  localparam int EW = KEY_FILED_NUM * KEY_FIELD_WIDTH;
  localparam int RN = 8;
  localparam int TO = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [HW-1:0] i_head = '0;
  logic [MW-1:0] i_meta = '0;
  logic [HW-1:0] o_head;
  logic [MW-1:0] o_meta;
  logic [HEAD_SHIFT_WIDTH-1:0] o_headShift;
  logic [META_SHIFT_WIDTH-1:0] o_metaShift;
  logic [EW-1:0] o_extField;
  logic i_cfg_wren = 1'b0;
  logic [$clog2(RN)-1:0] i_cfg_addr = '0;
  logic [$bits(rule_t)-1:0] i_cfg_wdata = '0;

  parser_field_extract #(.RULE_NUM(RN), .TYPE_OFFSET(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_head(i_head), .i_meta(i_meta),
    .o_head(o_head), .o_meta(o_meta), .o_headShift(o_headShift),
    .o_metaShift(o_metaShift), .o_extField(o_extField),
    .i_cfg_wren(i_cfg_wren), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HW-1:0] head;
    logic [MW-1:0] meta;
    logic [HEAD_SHIFT_WIDTH-1:0] hs;
    logic [META_SHIFT_WIDTH-1:0] ms;
    logic [EW-1:0] ext;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model state
  rule_t mtab[RN];
  logic [HEAD_SHIFT_WIDTH-1:0] cur_hs;
  logic [META_SHIFT_WIDTH-1:0] cur_ms;
  logic [EW-1:0] cur_ext;
  logic [7:0] pkt_bytes[NB];
  bit wr_pend = 0;
  logic [$clog2(RN)-1:0] wr_addr;
  rule_t wr_rule;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    for (int i = 0; i < RN; i++) mtab[i] = '0;
    cur_hs = '0; cur_ms = '0; cur_ext = '0;
    wr_pend = 0;
  endtask

  // Called just after a rising edge: drives one cycle of stimulus, records the
  // expected response, then waits for the next rising edge.
  task automatic step(input bit st, input bit vl, input bit tl);
    logic [HW-1:0] h;
    logic [MW-1:0] m;
    logic [15:0] ty;
    int idx;
    h = '0;
    for (int b = 0; b < NB; b++) h[HEAD_WIDTH-1-8*b -: 8] = pkt_bytes[b];
    h[HEAD_WIDTH+TAG_START] = st;
    h[HEAD_WIDTH+TAG_VALID] = vl;
    h[HEAD_WIDTH+TAG_TAIL]  = tl;
    for (int bi = 0; bi < MW; bi++) m[bi] = 1'($urandom_range(0, 1));
    i_head = h;
    i_meta = m;
    i_cfg_wren = wr_pend;
    i_cfg_addr = wr_addr;
    i_cfg_wdata = wr_rule;
    if (st && vl) begin
      ty = {pkt_bytes[TO], pkt_bytes[TO+1]};
      cur_hs = '0; cur_ms = '0; cur_ext = '0;
      for (int r = 0; r < RN; r++) begin
        if (mtab[r].valid && (((ty ^ mtab[r].type_value) & mtab[r].type_mask) == 16'h0)) begin
          cur_hs = mtab[r].action.head_shift;
          cur_ms = mtab[r].action.meta_shift;
          for (int k = 0; k < KEY_FILED_NUM; k++)
            for (int j = 0; j < KEY_FIELD_WIDTH / 8; j++) begin
              idx = int'(mtab[r].action.key_off[k]) + j;
              cur_ext = {cur_ext[EW-9:0], (idx < NB) ? pkt_bytes[idx] : 8'h00};
            end
          break;
        end
      end
    end
    if (vl) q.push_back('{h, m, cur_hs, cur_ms, cur_ext, cyc});
    if (wr_pend) mtab[wr_addr] = wr_rule;
    wr_pend = 0;
    @(posedge clk);
    #1;
    i_cfg_wren = 1'b0;
  endtask

  task automatic stage_write(input int a, input bit v, input logic [15:0] val,
                             input logic [15:0] msk, input int hs, input int ms,
                             input int o0, input int o1);
    wr_pend = 1;
    wr_addr = a[$clog2(RN)-1:0];
    wr_rule = '0;
    wr_rule.valid = v;
    wr_rule.type_value = val;
    wr_rule.type_mask = msk;
    wr_rule.action.head_shift = HEAD_SHIFT_WIDTH'(hs);
    wr_rule.action.meta_shift = META_SHIFT_WIDTH'(ms);
    wr_rule.action.key_off[0] = OFF_WIDTH_DEFAULT'(o0);
    wr_rule.action.key_off[1] = OFF_WIDTH_DEFAULT'(o1);
  endtask

  task automatic rand_bytes(input logic [15:0] ty);
    for (int b = 0; b < NB; b++) pkt_bytes[b] = 8'($urandom);
    pkt_bytes[TO] = ty[15:8];
    pkt_bytes[TO+1] = ty[7:0];
  endtask

  task automatic send_pkt(input logic [15:0] ty, input int n);
    rand_bytes(ty);
    step(1, 1, n == 1);
    for (int i = 1; i < n; i++) begin
      rand_bytes(16'($urandom));
      step(0, 1, i == n - 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_bytes(16'($urandom));
      step(0, 0, 0);
    end
  endtask

  task automatic write_only(input int a, input bit v, input logic [15:0] val,
                            input logic [15:0] msk, input int hs, input int ms,
                            input int o0, input int o1);
    stage_write(a, v, val, msk, hs, ms, o0, o1);
    idle(1);
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (o_head !== '0 || o_meta !== '0 || o_headShift !== '0 ||
        o_metaShift !== '0 || o_extField !== '0) begin
      fails++;
      $display("FAIL %s: got head_tag=%b meta_tag=%b hs=%0d ms=%0d ext=%h, required all zero",
               name, o_head[HW-1 -: TAG_WIDTH], o_meta[MW-1 -: TAG_WIDTH],
               o_headShift, o_metaShift, o_extField);
    end
  endtask

  function automatic logic [15:0] pick_type();
    case ($urandom_range(0, 5))
      0: return 16'h0800;
      1: return 16'h86DD;
      2: return 16'h8600;
      3: return 16'h1234;
      4: return 16'h86AB;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] pick_mask();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'hFF00;
      2: return 16'h00FF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: compares every valid slice leaving the DUT against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_head[HEAD_WIDTH+TAG_VALID]) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_slice: got a valid slice at cycle %0d, required none", cyc);
      end else begin
        mon_e = q.pop_front();
        tests++;
        if (o_head !== mon_e.head || cyc != mon_e.cyc + 2) begin
          fails++;
          $display("FAIL head: got %h at cycle %0d, required %h at cycle %0d",
                   o_head, cyc, mon_e.head, mon_e.cyc + 2);
        end
        tests++;
        if (o_meta !== mon_e.meta) begin
          fails++;
          $display("FAIL meta: got %h, required %h", o_meta, mon_e.meta);
        end
        tests++;
        if (o_headShift !== mon_e.hs || o_metaShift !== mon_e.ms || o_extField !== mon_e.ext) begin
          fails++;
          $display("FAIL ctrl at cycle %0d: got hs=%0d ms=%0d ext=%h, required hs=%0d ms=%0d ext=%h",
                   cyc, o_headShift, o_metaShift, o_extField, mon_e.hs, mon_e.ms, mon_e.ext);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int kind;
    model_reset();
    for (int b = 0; b < NB; b++) pkt_bytes[b] = 8'h00;
    #3;
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // table starts invalid: a matching-looking type misses
    send_pkt(16'h0800, 2);

    // basic hit with two key fields
    write_only(0, 1, 16'h0800, 16'hFFFF, 2, 1, 26, 30);
    send_pkt(16'h0800, 3);

    // priority: rules 1 and 3 both match, lowest index wins; offset 62 runs past the end
    write_only(1, 1, 16'h8600, 16'hFF00, 5, 3, 0, 62);
    write_only(3, 1, 16'h86DD, 16'hFFFF, 7, 9, 4, 8);
    send_pkt(16'h86DD, 2);

    // miss
    send_pkt(16'h1234, 3);

    // invalidate rule 0 in the same cycle as a lookup, then look up again
    rand_bytes(16'h0800);
    stage_write(0, 0, 16'h0800, 16'hFFFF, 2, 1, 26, 30);
    step(1, 1, 1);
    rand_bytes(16'h0800);
    step(1, 1, 1);
    idle(1);

    // back-to-back single-slice packets: hit, miss, hit
    write_only(0, 1, 16'h0800, 16'hFFFF, 2, 1, 26, 30);
    send_pkt(16'h0800, 1);
    send_pkt(16'h1234, 1);
    send_pkt(16'h0800, 1);
    idle(3);

    // reset in the middle of a packet
    send_pkt(16'h0800, 1);
    rand_bytes(16'h0800);
    step(1, 1, 0);
    rand_bytes(16'h0000);
    step(0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    model_reset();
    i_head = '0; i_meta = '0; i_cfg_wren = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    rand_bytes(16'h0000);
    step(0, 1, 1);
    send_pkt(16'h0800, 2);
    write_only(0, 1, 16'h0800, 16'hFFFF, 2, 1, 26, 30);
    send_pkt(16'h0800, 2);

    // randomized traffic and rule updates
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0)
        stage_write($urandom_range(0, RN - 1), $urandom_range(0, 3) != 0, pick_type(), pick_mask(),
                    $urandom_range(0, 63), $urandom_range(0, 31),
                    $urandom_range(0, 63), $urandom_range(0, 63));
      rand_bytes(pick_type());
      kind = $urandom_range(0, 9);
      if (kind < 2)       step(0, 0, 0);
      else if (kind < 5)  step(1, 1, 1'($urandom_range(0, 1)));
      else if (kind < 9)  step(0, 1, 1'($urandom_range(0, 1)));
      else                step(1, 0, 0);
    end

    idle(4);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d slices still outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parser_field_extract.md
# parser_field_extract

Parser stage directly upstream of the head/meta shift stage. On each packet's first head slice it matches a type field against a runtime-programmable rule table. The winning rule supplies the head shift, meta shift and byte offsets of the key fields. The block extracts those fields and presents them, together with the 2-cycle-delayed head and meta streams, aligned so the shift stage samples every control value on the same cycle as its start slice.

## Interface
Parameters:
- RULE_NUM, 8, number of rule entries (power of two)
- TYPE_OFFSET, 12, byte offset of the 16-bit type field in the first slice
- OFF_WIDTH, $clog2(`HEAD_WIDTH/8), width of a byte offset inside one slice

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  reset; asynchronous, active-low
- i_head  in  `HEAD_WIDTH+`TAG_WIDTH  head slice with tag (start/valid/tail bits)
- i_meta  in  `META_WIDTH+`TAG_WIDTH  meta slice with tag
- o_head  out  `HEAD_WIDTH+`TAG_WIDTH  i_head delayed 2 cycles, unmodified
- o_meta  out  `META_WIDTH+`TAG_WIDTH  i_meta delayed 2 cycles, unmodified
- o_headShift  out  `HEAD_SHIFT_WIDTH  head shift of the current packet
- o_metaShift  out  `META_SHIFT_WIDTH  meta shift of the current packet
- o_extField  out  `KEY_FILED_NUM*`KEY_FIELD_WIDTH  extracted key fields; field 0 in the MSBs
- i_cfg_wren  in  1  rule write strobe
- i_cfg_addr  in  $clog2(RULE_NUM)  rule index
- i_cfg_wdata  in  rule_t width  packed rule: valid, type value[16], type mask[16], headShift, metaShift, key offsets[`KEY_FILED_NUM] of OFF_WIDTH each

## Operation
- Start slice: tag START=1 and VALID=1 at i_head. START without VALID is ignored and treated as a non-start slice.
- Cycle S (start slice at input):
  - Extract type = bytes TYPE_OFFSET..TYPE_OFFSET+1 of the slice, big-endian.
  - Build match vector: hit[i] = valid[i] & ((type ^ value[i]) & mask[i]) == 0.
  - Register the match vector and the data part of the slice.
- Cycle S+1:
  - Priority-encode the match vector; the lowest index wins.
  - Load o_headShift and o_metaShift from the winning rule.
  - For each key field k, load o_extField[k] = `KEY_FIELD_WIDTH bits starting at byte offset[k] of the registered slice.
  - Bits past the slice end read as 0; no wrap-around into the next slice.
- Miss (no hit): o_headShift=0, o_metaShift=0, o_extField=0. The packet passes through unshifted.
- Non-start cycles: o_headShift, o_metaShift and o_extField hold their values until the next start slice.
- Back-to-back one-slice packets (START on consecutive cycles): each slice gets its own lookup with no bubble.
- Config writes:
  - A write in cycle W updates the entry at the end of W.
  - A start slice in cycle W+1 or later sees the new rule.
  - A start slice in cycle W sees the old rule.
  - A simultaneous write and lookup on the same entry is legal.
- Reset:
  - All outputs are 0, including tag bits, so downstream sees no slices.
  - All rule valid bits are 0.
  - Pipeline contents are discarded.
  - Reset mid-packet truncates the packet. The next start slice after release is handled normally.

## Timing
- Latency is exactly 2 cycles, i_head to o_head and i_meta to o_meta.
- o_headShift, o_metaShift and o_extField for a packet change on the same clock edge that presents its start slice on o_head. They are stable throughout that packet.
- Throughput: one slice per cycle. No backpressure, no stall input.
- Table storage is flops (RULE_NUM × rule_t). Reads are combinational in cycle S.

## Structure
- The shared parser define/package gains:
  - typedef rule_t (field order as listed for i_cfg_wdata, valid in the MSB)
  - RULE_NUM_DEFAULT
  - TYPE_OFFSET_DEFAULT
- One sub-module, parser_rule_match:
  - contains the rule table, the write port and the hit-vector generation
  - output is the registered hit vector
- Priority encode and field extraction stay in the top module.

## Test plan
- Rule 0 = {valid, 0x0800, 0xFFFF, headShift=2, metaShift=1, offsets 26,30}. Packet with type 0x0800 at byte 12 -> at the start slice o_headShift=2, o_metaShift=1, o_extField = {bytes 26-29, bytes 30-33}; o_head equals i_head delayed 2 cycles.
- Rules 1 = {0x8600, mask 0xFF00} and 3 = {0x86DD, mask 0xFFFF} both valid. Type 0x86DD -> rule 1 wins.
- Type 0x1234 with no match -> all shifts and o_extField are 0; data passes through unchanged.
- Write rule 0 to invalid in cycle W with a start slice at W and another at W+1 -> first slice hits, second misses.
- Three consecutive one-slice packets with types 0x0800, 0x1234, 0x0800 -> outputs per slice are hit, miss, hit with no bubbles.
- Assert i_rst_n low mid-packet -> all outputs 0 asynchronously and the table is invalidated; after release and reprogramming, the next packet is handled correctly.
